// File: rtl/uart_rx.sv
// uart_rx -- serial receive engine.
//
// Oversamples the asynchronous serial line at SAMPLING_RATE ticks per bit
// and deframes start / data / parity / stop. Frame format (7 or 8 data bits,
// 1 or 2 stop bits, none/even/odd parity) is captured when a start edge is
// seen, so the controls may change freely while a frame is in flight.
// Each completed character is presented with a one-cycle strobe and its
// error flags; data and flags then hold until the next completion.
//
// Parameters
//   DBITS          maximum data bits per frame (7-bit mode uses DBITS-1)
//   SBITS          maximum stop bits per frame
//   SAMPLING_RATE  oversampling ticks per bit (even, >= 4)
//
// Ports
//   i_clk      system clock, all state on the rising edge
//   i_rst_n    asynchronous active-low reset
//   i_rx       serial line, asynchronous to i_clk, idle high
//   i_s_tick   oversampling tick, one i_clk cycle wide
//   i_d_num    0 = 7 data bits, 1 = 8 data bits
//   i_s_num    0 = 1 stop bit, 1 = 2 stop bits
//   i_par      00 none, 01 even, 10 odd, 11 none
//   o_rx_data  last received character, right-aligned
//   o_rx_done  one-cycle strobe: character and flags valid
//   o_par_err  parity mismatch for the character in o_rx_data
//   o_frm_err  a sampled stop bit was 0

module uart_rx #(
  parameter int DBITS         = 8,
  parameter int SBITS         = 2,
  parameter int SAMPLING_RATE = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rx,
  input  logic             i_s_tick,
  input  logic             i_d_num,
  input  logic             i_s_num,
  input  logic [1:0]       i_par,
  output logic [DBITS-1:0] o_rx_data,
  output logic             o_rx_done,
  output logic             o_par_err,
  output logic             o_frm_err
);

  localparam int TW   = $clog2(SAMPLING_RATE);
  localparam int NMAX = (DBITS > SBITS) ? DBITS : SBITS;
  localparam int NW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  // Tick-count values at which a sample is taken.
  localparam logic [TW-1:0] T_HALF = TW'(SAMPLING_RATE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(SAMPLING_RATE - 1);

  // Bit-counter values of the last data / stop bit for each format.
  localparam logic [NW-1:0] N_LAST_D_WIDE   = NW'(DBITS - 1);
  localparam logic [NW-1:0] N_LAST_D_NARROW = NW'(DBITS - 2);
  localparam logic [NW-1:0] N_LAST_S_WIDE   = NW'(SBITS - 1);
  localparam logic [NW-1:0] N_LAST_S_NARROW = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Line synchronizer
  logic rx_meta_reg;
  logic rx_s_reg;

  // Frame engine
  state_t           state_reg, state_next;
  logic [TW-1:0]    t_reg, t_next;
  logic [NW-1:0]    n_reg, n_next;
  logic [DBITS-1:0] shreg_reg, shreg_next;

  // Format captured at start of frame
  logic d_num_reg, d_num_next;
  logic s_num_reg, s_num_next;
  logic par_en_reg, par_en_next;
  logic par_odd_reg, par_odd_next;

  // Errors accumulated while the frame is in progress
  logic par_pend_reg, par_pend_next;
  logic frm_pend_reg, frm_pend_next;

  // Registered outputs
  logic [DBITS-1:0] data_out_reg, data_out_next;
  logic             done_reg, done_next;
  logic             par_err_reg, par_err_next;
  logic             frm_err_reg, frm_err_next;

  // Helpers
  logic [DBITS-1:0] aligned_data;
  logic [NW-1:0]    n_data_last;
  logic [NW-1:0]    n_stop_last;
  logic             ones_odd;
  logic             frm_now;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer; resets to the idle (high) line level.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= i_rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Data alignment. Bits enter at the MSB and move right, so after a
  // 7-bit frame the character sits in [DBITS-1:1]; shift it down one
  // place and force the top bit to zero.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DBITS; gi++) begin : g_align
      if (gi == DBITS - 1) begin : g_top
        assign aligned_data[gi] = d_num_reg & shreg_reg[gi];
      end else begin : g_low
        assign aligned_data[gi] = d_num_reg ? shreg_reg[gi] : shreg_reg[gi+1];
      end
    end
  endgenerate

  assign n_data_last = d_num_reg ? N_LAST_D_WIDE : N_LAST_D_NARROW;
  assign n_stop_last = s_num_reg ? N_LAST_S_WIDE : N_LAST_S_NARROW;

  // The shift register is cleared at frame start, so the unused LSB in
  // 7-bit mode is 0 and the reduction XOR gives the data parity directly.
  assign ones_odd = ^shreg_reg;

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      t_reg        <= '0;
      n_reg        <= '0;
      shreg_reg    <= '0;
      d_num_reg    <= 1'b0;
      s_num_reg    <= 1'b0;
      par_en_reg   <= 1'b0;
      par_odd_reg  <= 1'b0;
      par_pend_reg <= 1'b0;
      frm_pend_reg <= 1'b0;
      data_out_reg <= '0;
      done_reg     <= 1'b0;
      par_err_reg  <= 1'b0;
      frm_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      t_reg        <= t_next;
      n_reg        <= n_next;
      shreg_reg    <= shreg_next;
      d_num_reg    <= d_num_next;
      s_num_reg    <= s_num_next;
      par_en_reg   <= par_en_next;
      par_odd_reg  <= par_odd_next;
      par_pend_reg <= par_pend_next;
      frm_pend_reg <= frm_pend_next;
      data_out_reg <= data_out_next;
      done_reg     <= done_next;
      par_err_reg  <= par_err_next;
      frm_err_reg  <= frm_err_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    t_next        = t_reg;
    n_next        = n_reg;
    shreg_next    = shreg_reg;
    d_num_next    = d_num_reg;
    s_num_next    = s_num_reg;
    par_en_next   = par_en_reg;
    par_odd_next  = par_odd_reg;
    par_pend_next = par_pend_reg;
    frm_pend_next = frm_pend_reg;
    data_out_next = data_out_reg;
    done_next     = 1'b0;
    par_err_next  = par_err_reg;
    frm_err_next  = frm_err_reg;
    frm_now       = frm_pend_reg | ~rx_s_reg;

    case (state_reg)
      ST_IDLE: begin
        if (!rx_s_reg) begin
          state_next    = ST_START;
          t_next        = '0;
          n_next        = '0;
          shreg_next    = '0;
          d_num_next    = i_d_num;
          s_num_next    = i_s_num;
          // 11 is an alias for "no parity"
          par_en_next   = i_par[0] ^ i_par[1];
          par_odd_next  = i_par[1];
          par_pend_next = 1'b0;
          frm_pend_next = 1'b0;
        end
      end

      ST_START: begin
        if (i_s_tick) begin
          if (t_reg == T_HALF) begin
            t_next = '0;
            // Line back high at mid start bit: a glitch, not a frame.
            state_next = rx_s_reg ? ST_IDLE : ST_DATA;
          end else begin
            t_next = t_reg + TW'(1);
          end
        end
      end

      ST_DATA: begin
        if (i_s_tick) begin
          if (t_reg == T_FULL) begin
            t_next     = '0;
            shreg_next = {rx_s_reg, shreg_reg[DBITS-1:1]};
            if (n_reg == n_data_last) begin
              n_next     = '0;
              state_next = par_en_reg ? ST_PARITY : ST_STOP;
            end else begin
              n_next = n_reg + NW'(1);
            end
          end else begin
            t_next = t_reg + TW'(1);
          end
        end
      end

      ST_PARITY: begin
        if (i_s_tick) begin
          if (t_reg == T_FULL) begin
            t_next        = '0;
            // Even parity wants an even total, odd parity an odd total.
            par_pend_next = (ones_odd ^ rx_s_reg) != par_odd_reg;
            state_next    = ST_STOP;
          end else begin
            t_next = t_reg + TW'(1);
          end
        end
      end

      ST_STOP: begin
        if (i_s_tick) begin
          if (t_reg == T_FULL) begin
            t_next = '0;
            if (n_reg == n_stop_last) begin
              // Frame complete at mid final stop bit; leaving here early
              // lets a back-to-back start edge be caught.
              n_next        = '0;
              data_out_next = aligned_data;
              par_err_next  = par_pend_reg;
              frm_err_next  = frm_now;
              done_next     = 1'b1;
              frm_pend_next = frm_now;
              state_next    = frm_now ? ST_BREAK : ST_IDLE;
            end else begin
              n_next        = n_reg + NW'(1);
              frm_pend_next = frm_now;
            end
          end else begin
            t_next = t_reg + TW'(1);
          end
        end
      end

      ST_BREAK: begin
        // Wait out a held-low line so it is not mistaken for a new start.
        if (rx_s_reg) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_rx_data = data_out_reg;
  assign o_rx_done = done_reg;
  assign o_par_err = par_err_reg;
  assign o_frm_err = frm_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_rx;
  logic       i_s_tick;
  logic       i_d_num;
  logic       i_s_num;
  logic [1:0] i_par;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_par_err;
  logic       o_frm_err;

  int checks = 0;
  int passes = 0;

  // Received strobes: {data, par_err, frm_err}
  logic [9:0] rxq[$];
  logic       done_prev = 1'b0;

  uart_rx #(
    .DBITS(8),
    .SBITS(2),
    .SAMPLING_RATE(16)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_rx     (i_rx),
    .i_s_tick (i_s_tick),
    .i_d_num  (i_d_num),
    .i_s_num  (i_s_num),
    .i_par    (i_par),
    .o_rx_data(o_rx_data),
    .o_rx_done(o_rx_done),
    .o_par_err(o_par_err),
    .o_frm_err(o_frm_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // One tick every 4 clocks, changed on the falling edge.
  initial begin
    i_s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge i_clk);
      i_s_tick = 1'b1;
      @(negedge i_clk);
      i_s_tick = 1'b0;
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Strobe monitor
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_rx_done === 1'b1) begin
        check("done_single_cycle", {31'd0, done_prev}, 32'd0);
        rxq.push_back({o_rx_data, o_par_err, o_frm_err});
      end
      done_prev = o_rx_done;
    end
  end

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge i_clk); while (i_s_tick !== 1'b1);
    end
    @(negedge i_clk);
  endtask

  task automatic drive_line(input logic v, input int ticks);
    i_rx = v;
    wait_ticks(ticks);
  endtask

  // Drives one frame and returns the expected {data, par_err, frm_err},
  // derived from the framing rules.
  task automatic send_frame(input logic [7:0] d, input logic d8, input logic s2,
                            input logic [1:0] par, input logic pbit,
                            input logic stop_val, input logic scramble,
                            output logic [9:0] exp);
    int ones;
    int nd;
    logic [7:0] dv;
    logic ep;
    i_d_num = d8;
    i_s_num = s2;
    i_par   = par;
    drive_line(1'b0, 16);
    if (scramble) {i_d_num, i_s_num, i_par} = 4'($urandom);
    nd = d8 ? 8 : 7;
    for (int i = 0; i < nd; i++) drive_line(d[i], 16);
    if (par == 2'b01 || par == 2'b10) drive_line(pbit, 16);
    for (int i = 0; i < (s2 ? 2 : 1); i++) drive_line(stop_val, 16);
    dv   = d8 ? d : (d & 8'h7F);
    ones = $countones(dv);
    if (par == 2'b01)      ep = ((ones + int'(pbit)) % 2) != 0;
    else if (par == 2'b10) ep = ((ones + int'(pbit)) % 2) != 1;
    else                   ep = 1'b0;
    exp = {dv, ep, ~stop_val};
  endtask

  task automatic check_frame(input string tag, input logic [9:0] exp);
    int waited = 0;
    logic [9:0] got;
    while (rxq.size() == 0 && waited < 200) begin
      @(negedge i_clk);
      waited++;
    end
    check({tag, "_strobes"}, rxq.size(), 32'd1);
    if (rxq.size() > 0) begin
      got = rxq.pop_front();
      check({tag, "_data"}, {24'd0, got[9:2]}, {24'd0, exp[9:2]});
      check({tag, "_par_err"}, {31'd0, got[1]}, {31'd0, exp[1]});
      check({tag, "_frm_err"}, {31'd0, got[0]}, {31'd0, exp[0]});
      $display("frame %s: data=0x%02h par_err=%0b frm_err=%0b (exp 0x%02h %0b %0b)",
               tag, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
    end
    rxq.delete();
  endtask

  initial begin
    logic [9:0] exp;
    logic [7:0] rd;
    logic       rd8, rs2, rpb, rstop, rscr;
    logic [1:0] rpar;

    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    i_d_num = 1'b1;
    i_s_num = 1'b0;
    i_par   = 2'b00;
    repeat (3) @(negedge i_clk);
    check("reset_data", {24'd0, o_rx_data}, 32'd0);
    check("reset_done", {31'd0, o_rx_done}, 32'd0);
    check("reset_par_err", {31'd0, o_par_err}, 32'd0);
    check("reset_frm_err", {31'd0, o_frm_err}, 32'd0);
    i_rst_n = 1'b1;
    drive_line(1'b1, 32);

    // 8N1 0xA5
    send_frame(8'hA5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, exp);
    check_frame("8N1_A5", exp);
    drive_line(1'b1, 16);

    // 7E2 0x53 (4 ones, parity bit 0), then 7O1 0x53 (parity bit 1)
    send_frame(8'h53, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, exp);
    check_frame("7E2_53", exp);
    send_frame(8'h53, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, exp);
    check_frame("7O1_53", exp);
    drive_line(1'b1, 16);

    // 8O1 0x3C with a mismatching parity bit, then a good frame
    send_frame(8'h3C, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, exp);
    check("8O1_bad_expect", {31'd0, exp[1]}, 32'd1);
    check_frame("8O1_3C_bad", exp);
    send_frame(8'h3C, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, exp);
    check_frame("8O1_3C_good", exp);
    drive_line(1'b1, 16);

    // 8N1 0x55 with stop forced low, line low 3 more bits, then 0x0F
    send_frame(8'h55, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, exp);
    check_frame("8N1_55_frm", exp);
    drive_line(1'b0, 48);
    drive_line(1'b1, 16);
    check("break_no_strobe", rxq.size(), 32'd0);
    send_frame(8'h0F, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, exp);
    check_frame("8N1_0F", exp);

    // Short glitch on idle line: no strobe, outputs hold
    drive_line(1'b1, 16);
    drive_line(1'b0, 4);
    drive_line(1'b1, 32);
    check("glitch_no_strobe", rxq.size(), 32'd0);
    check("glitch_hold_data", {24'd0, o_rx_data}, {24'd0, exp[9:2]});
    check("glitch_hold_frm", {31'd0, o_frm_err}, 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, exp);
    check_frame("8N1_81", exp);
    drive_line(1'b1, 16);

    // Reset during data bit 3 of 0xFF
    i_d_num = 1'b1; i_s_num = 1'b0; i_par = 2'b00;
    drive_line(1'b0, 16);
    drive_line(1'b1, 48 + 8);
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    check("midrst_data", {24'd0, o_rx_data}, 32'd0);
    check("midrst_done", {31'd0, o_rx_done}, 32'd0);
    check("midrst_par_err", {31'd0, o_par_err}, 32'd0);
    check("midrst_frm_err", {31'd0, o_frm_err}, 32'd0);
    i_rst_n = 1'b1;
    drive_line(1'b1, 48);
    check("midrst_no_strobe", rxq.size(), 32'd0);
    send_frame(8'h12, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, exp);
    check_frame("8N1_12", exp);

    // Random formats, data, parity bits, stop errors and mid-frame
    // config changes; frames often back-to-back.
    for (int it = 0; it < 24; it++) begin
      rd    = 8'($urandom);
      rd8   = 1'($urandom);
      rs2   = 1'($urandom);
      rpar  = 2'($urandom);
      rpb   = 1'($urandom);
      rstop = ($urandom_range(0, 5) != 0);
      rscr  = 1'($urandom);
      send_frame(rd, rd8, rs2, rpar, rpb, rstop, rscr, exp);
      check_frame($sformatf("rand%0d", it), exp);
      if (!rstop) begin
        drive_line(1'b0, $urandom_range(0, 40));
        drive_line(1'b1, 16);
        check("rand_break_quiet", rxq.size(), 32'd0);
      end else if ($urandom_range(0, 1) == 1) begin
        drive_line(1'b1, $urandom_range(1, 20));
      end
    end

    drive_line(1'b1, 16);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
